// File: rtl/slot_controller.sv
// ============================================================================
// slot_controller
// ----------------------------------------------------------------------------
// Wishbone-controlled manager for NSLOTS accelerator slots. Software enables
// slots, kicks them with a START write and observes busy / done / timeout in
// STATUS. Each slot runs a small IDLE/RUN state machine. An optional per-slot
// watchdog aborts a run that exceeds the TMO limit and soft-resets the slot.
//
// Optional feature macro: SLOT_TIMEOUT_EN
//   defined   -> TMO register and per-slot timeout counters are built
//   undefined -> no counters, TMO and timeout bits read 0, a slot leaves RUN
//                only through done or disable
//
// Parameters
//   NSLOTS  number of slots (1..8)
//   TMO_W   width of the timeout counters and limit register (8..32)
//
// Ports
//   wb_clk_i      clock
//   wb_rst_i      synchronous active-high reset
//   wbs_stb_i     Wishbone strobe
//   wbs_cyc_i     Wishbone cycle
//   wbs_we_i      write enable
//   wbs_sel_i     byte selects (unused, writes are full-word)
//   wbs_adr_i     address, [4:2] selects the register
//   wbs_dat_i     write data
//   wbs_ack_o     acknowledge, one cycle
//   wbs_dat_o     read data, valid only while wbs_ack_o is high, else 0
//   slot_start_o  per-slot start pulse
//   slot_rst_o    per-slot soft-reset pulse
//   slot_done_i   per-slot completion (level or pulse)
//   irq_o         level interrupt
//
// Register map (word index)
//   0 CTRL    [NSLOTS-1:0] enable
//   1 START   write 1 to start a slot, reads 0
//   2 STATUS  [7:0] busy, [15:8] done (W1C), [23:16] timeout (W1C)
//   3 TMO     [TMO_W-1:0] timeout limit
//   4 IMASK   [1:0] {timeout_ie, done_ie}
//   5..7      read 0, writes ignored
// ============================================================================
module slot_controller #(
    parameter int NSLOTS = 4,
    parameter int TMO_W  = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic [NSLOTS-1:0] slot_start_o,
    output logic [NSLOTS-1:0] slot_rst_o,
    input  logic [NSLOTS-1:0] slot_done_i,
    output logic              irq_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } slot_state_t;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_START  = 3'd1;
    localparam logic [2:0] A_STATUS = 3'd2;
    localparam logic [2:0] A_TMO    = 3'd3;
    localparam logic [2:0] A_IMASK  = 3'd4;

    // ------------------------------------------------------------------------
    // Bus handshake: a request is stb & cyc while no ack is outstanding. The
    // request is accepted on that edge (address, direction and data are
    // captured), ack is raised for exactly the following cycle, and the
    // access completes in that ack cycle: a write updates its register on the
    // edge that ends the ack cycle, a read presents data only while ack is
    // high. Because a request is never recognised during the ack cycle, the
    // earliest next access starts after the write has landed.
    // ------------------------------------------------------------------------
    logic        r_ack;
    logic        r_we;
    logic [2:0]  r_idx;
    logic [31:0] r_wdat;
    logic        w_req;
    logic        w_wr_en;

    assign w_req   = wbs_stb_i & wbs_cyc_i & ~r_ack;
    assign w_wr_en = r_ack & r_we;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack  <= 1'b0;
            r_we   <= 1'b0;
            r_idx  <= 3'd0;
            r_wdat <= 32'd0;
        end else begin
            r_ack <= w_req;
            if (w_req) begin
                r_we   <= wbs_we_i;
                r_idx  <= wbs_adr_i[4:2];
                r_wdat <= wbs_dat_i;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------------
    logic [NSLOTS-1:0] r_ctrl;
    logic [NSLOTS-1:0] r_done;
    logic [NSLOTS-1:0] r_tmo_st;
    logic [1:0]        r_imask;
    logic              r_irq;

    logic [NSLOTS-1:0] w_start_req;
    logic [NSLOTS-1:0] w_clr_done;
    logic [NSLOTS-1:0] w_clr_tmo;

    assign w_start_req = (w_wr_en && r_idx == A_START)  ? r_wdat[NSLOTS-1:0]  : '0;
    assign w_clr_done  = (w_wr_en && r_idx == A_STATUS) ? r_wdat[8 +: NSLOTS]  : '0;
    assign w_clr_tmo   = (w_wr_en && r_idx == A_STATUS) ? r_wdat[16 +: NSLOTS] : '0;

    // ------------------------------------------------------------------------
    // Per-slot FSM signals. The busy field of STATUS is a direct view of the
    // FSM state vector, so every slot's state is observable over the bus.
    // ------------------------------------------------------------------------
    slot_state_t       r_state     [NSLOTS];
    slot_state_t       w_state_nxt [NSLOTS];
    logic [NSLOTS-1:0] w_busy;
    logic [NSLOTS-1:0] w_start;
    logic [NSLOTS-1:0] w_srst;
    logic [NSLOTS-1:0] w_set_done;
    logic [NSLOTS-1:0] w_set_tmo;
    logic [NSLOTS-1:0] w_expired;

`ifdef SLOT_TIMEOUT_EN
    // ------------------------------------------------------------------------
    // Watchdog: counter clears on start, counts every RUN cycle and saturates.
    // A limit of 0 behaves like 1. The compare uses >= so that lowering TMO
    // below the current count mid-run still expires the slot instead of
    // letting it run until saturation.
    // ------------------------------------------------------------------------
    logic [TMO_W-1:0] r_tmo;
    logic [TMO_W-1:0] r_cnt [NSLOTS];
    logic [TMO_W-1:0] w_lim_m1;

    assign w_lim_m1 = (r_tmo == '0) ? '0 : r_tmo - TMO_W'(1);

    always_comb begin
        w_expired = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            w_expired[i] = (r_cnt[i] >= w_lim_m1);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_tmo <= '1;
            for (int i = 0; i < NSLOTS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            if (w_wr_en && r_idx == A_TMO) begin
                r_tmo <= r_wdat[TMO_W-1:0];
            end
            for (int i = 0; i < NSLOTS; i++) begin
                if (w_start[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_state[i] == S_RUN && r_cnt[i] != '1) begin
                    r_cnt[i] <= r_cnt[i] + TMO_W'(1);
                end
            end
        end
    end
`else
    assign w_expired = '0;
`endif

    // ------------------------------------------------------------------------
    // Slot FSMs: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NSLOTS; i++) begin
                r_state[i] <= S_IDLE;
            end
        end else begin
            for (int i = 0; i < NSLOTS; i++) begin
                r_state[i] <= w_state_nxt[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Slot FSMs: next state and pulses. Exit priority from RUN is
    // done > timeout > disable, so a completion that coincides with the
    // watchdog or with a disable is reported as done with no soft reset.
    // ------------------------------------------------------------------------
    always_comb begin
        w_start    = '0;
        w_srst     = '0;
        w_set_done = '0;
        w_set_tmo  = '0;
        w_busy     = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_busy[i]      = (r_state[i] == S_RUN);
            case (r_state[i])
                S_IDLE: begin
                    if (w_start_req[i] && r_ctrl[i]) begin
                        w_state_nxt[i] = S_RUN;
                        w_start[i]     = 1'b1;
                    end
                end
                S_RUN: begin
                    if (slot_done_i[i]) begin
                        w_state_nxt[i] = S_IDLE;
                        w_set_done[i]  = 1'b1;
                    end else if (w_expired[i]) begin
                        w_state_nxt[i] = S_IDLE;
                        w_set_tmo[i]   = 1'b1;
                        w_srst[i]      = 1'b1;
                    end else if (!r_ctrl[i]) begin
                        w_state_nxt[i] = S_IDLE;
                        w_srst[i]      = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt[i] = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Register writes and sticky bits (set wins over a same-cycle W1C)
    // ------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ctrl   <= '0;
            r_done   <= '0;
            r_tmo_st <= '0;
            r_imask  <= 2'b00;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_en && r_idx == A_CTRL) begin
                r_ctrl <= r_wdat[NSLOTS-1:0];
            end
            if (w_wr_en && r_idx == A_IMASK) begin
                r_imask <= r_wdat[1:0];
            end
            r_done   <= (r_done & ~w_clr_done) | w_set_done;
            r_tmo_st <= (r_tmo_st & ~w_clr_tmo) | w_set_tmo;
            r_irq    <= (r_imask[0] & (|r_done)) | (r_imask[1] & (|r_tmo_st));
        end
    end

    // ------------------------------------------------------------------------
    // Read mux, driven only during the ack cycle
    // ------------------------------------------------------------------------
    logic [31:0] w_rd;

    always_comb begin
        w_rd = '0;
        if (r_ack) begin
            case (r_idx)
                A_CTRL: begin
                    w_rd[NSLOTS-1:0] = r_ctrl;
                end
                A_STATUS: begin
                    w_rd[NSLOTS-1:0]    = w_busy;
                    w_rd[8 +: NSLOTS]  = r_done;
                    w_rd[16 +: NSLOTS] = r_tmo_st;
                end
                A_TMO: begin
`ifdef SLOT_TIMEOUT_EN
                    w_rd[TMO_W-1:0] = r_tmo;
`else
                    w_rd = '0;
`endif
                end
                A_IMASK: begin
                    w_rd[1:0] = r_imask;
                end
                default: begin
                    w_rd = '0;
                end
            endcase
        end
    end

    // Outputs are forced low while reset is held so that an ack or pulse
    // already in flight when reset arrives is aborted.
    assign wbs_ack_o    = r_ack & ~wb_rst_i;
    assign wbs_dat_o    = wb_rst_i ? 32'd0 : w_rd;
    assign slot_start_o = wb_rst_i ? '0 : w_start;
    assign slot_rst_o   = wb_rst_i ? '0 : w_srst;
    assign irq_o        = r_irq & ~wb_rst_i;

    // Address bits outside [4:2], byte selects and unused write-data bits.
    logic w_unused;
    assign w_unused = ^{wbs_sel_i, wbs_adr_i[31:5], wbs_adr_i[1:0], r_wdat};

endmodule

// File: tb/tb_slot_controller.sv
// ============================================================================
// tb_slot_controller
// Directed bench for slot_controller (NSLOTS=4, TMO_W=16). Timeout-only
// sequences are compiled in when SLOT_TIMEOUT_EN is defined.
// ============================================================================
module tb_slot_controller;

    localparam int NS = 4;

    localparam logic [2:0] I_CTRL   = 3'd0;
    localparam logic [2:0] I_START  = 3'd1;
    localparam logic [2:0] I_STATUS = 3'd2;
    localparam logic [2:0] I_TMO    = 3'd3;
    localparam logic [2:0] I_IMASK  = 3'd4;
    localparam logic [2:0] I_RSVD   = 3'd5;

`ifdef SLOT_TIMEOUT_EN
    localparam logic [31:0] TMO_RESET = 32'h0000_FFFF;
    localparam logic [31:0] RST3_EXP  = 32'd1;
`else
    localparam logic [31:0] TMO_RESET = 32'h0000_0000;
    localparam logic [31:0] RST3_EXP  = 32'd0;
`endif

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stb = 1'b0;
    logic          cyc = 1'b0;
    logic          we  = 1'b0;
    logic [3:0]    sel = 4'hF;
    logic [31:0]   adr = 32'd0;
    logic [31:0]   wdat = 32'd0;
    logic          ack;
    logic [31:0]   rdat;
    logic [NS-1:0] slot_start;
    logic [NS-1:0] slot_rst;
    logic [NS-1:0] slot_done = '0;
    logic          irq;

    always #5 clk = ~clk;

    slot_controller #(
        .NSLOTS (NS),
        .TMO_W  (16)
    ) u_dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wbs_stb_i    (stb),
        .wbs_cyc_i    (cyc),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_adr_i    (adr),
        .wbs_dat_i    (wdat),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (rdat),
        .slot_start_o (slot_start),
        .slot_rst_o   (slot_rst),
        .slot_done_i  (slot_done),
        .irq_o        (irq)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    int          last_lat = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Pulse monitor, sampled mid-cycle
    int start_cnt [NS];
    int rst_cnt   [NS];

    always @(negedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (slot_start[i]) start_cnt[i]++;
            if (slot_rst[i])   rst_cnt[i]++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [2:0] idx, input logic [31:0] d);
        int   n;
        logic seen;
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b1;
        adr = {27'd0, idx, 2'b00};
        wdat = d;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 8) begin
            @(posedge clk); #1;
            n++;
            if (ack) seen = 1'b1;
        end
        if (!seen) check_eq("wr_ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        last_lat = n;
    endtask

    task automatic wb_read(input logic [2:0] idx, output logic [31:0] d);
        int   n;
        logic seen;
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b0;
        adr = {27'd0, idx, 2'b00};
        seen = 1'b0;
        n = 0;
        d = '0;
        while (!seen && n < 8) begin
            @(posedge clk); #1;
            n++;
            if (ack) begin
                seen = 1'b1;
                d = rdat;
            end
        end
        if (!seen) check_eq("rd_ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0;
        last_lat = n;
    endtask

    task automatic check_rd(input logic [2:0] idx, input logic [31:0] exp, input string tag);
        logic [31:0] got;
        exp_q.push_back(exp);
        wb_read(idx, got);
        check_eq(tag, got, exp_q.pop_front());
    endtask

    task automatic pulse_done(input int slot);
        slot_done[slot] = 1'b1;
        tick(1);
        slot_done[slot] = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset state
        tick(3);
        check_eq("rst_ack", {31'd0, ack}, 32'd0);
        check_eq("rst_dat", rdat, 32'd0);
        check_eq("rst_pulses", {23'd0, slot_start, slot_rst, irq}, 32'd0);
        rst = 1'b0;
        tick(1);

        // Handshake: TMO read after reset
        check_rd(I_TMO, TMO_RESET, "tmo_reset");
        check_eq("ack_latency", last_lat, 32'd1);
        check_eq("ack_low_after", {31'd0, ack}, 32'd0);
        check_eq("dat_idle_zero", rdat, 32'd0);
        check_rd(I_CTRL, 32'd0, "ctrl_reset");
        check_rd(I_STATUS, 32'd0, "status_reset");
        check_rd(I_IMASK, 32'd0, "imask_reset");

        // Reserved index and out-of-range slot bits
        wb_write(I_RSVD, 32'hFFFF_FFFF);
        check_rd(I_RSVD, 32'd0, "rsvd_read");
        wb_write(I_CTRL, 32'h0000_00FF);
        check_rd(I_CTRL, 32'h0000_000F, "ctrl_mask");
        wb_write(I_IMASK, 32'hFFFF_FFFD);
        check_rd(I_IMASK, 32'h0000_0001, "imask_mask");

        // Done path on slot 0
        wb_write(I_START, 32'h1);
        check_eq("start0_pulse", start_cnt[0], 32'd1);
        check_rd(I_STATUS, 32'h0000_0001, "busy0");
        tick(3);
        pulse_done(0);
        tick(2);
        check_eq("irq_done", {31'd0, irq}, 32'd1);
        check_rd(I_STATUS, 32'h0000_0100, "status_done0");
        check_eq("done0_no_srst", rst_cnt[0], 32'd0);
        check_rd(I_START, 32'd0, "start_reads0");

        // Done while IDLE is ignored
        pulse_done(0);
        tick(1);
        check_rd(I_STATUS, 32'h0000_0100, "done_idle_ignored");

        // Sticky set beats a same-cycle W1C
        wb_write(I_START, 32'h1);
        check_eq("start0_again", start_cnt[0], 32'd2);
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b1;
        adr = {27'd0, I_STATUS, 2'b00};
        wdat = 32'h0000_0100;
        @(posedge clk); #1;
        check_eq("sticky_ack", {31'd0, ack}, 32'd1);
        slot_done[0] = 1'b1;
        @(posedge clk); #1;
        slot_done[0] = 1'b0;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        check_rd(I_STATUS, 32'h0000_0100, "set_wins_w1c");

        // W1C clears done, irq falls one cycle later
        wb_write(I_STATUS, 32'h0000_0100);
        tick(1);
        check_eq("irq_cleared", {31'd0, irq}, 32'd0);
        check_rd(I_STATUS, 32'd0, "status_cleared");

        // Ignored starts: disabled slot, then already-running slot
        wb_write(I_CTRL, 32'h3);
        wb_write(I_START, 32'h4);
        check_eq("start_disabled", start_cnt[2], 32'd0);
        check_rd(I_STATUS, 32'd0, "disabled_not_busy");
        wb_write(I_START, 32'h2);
        check_eq("start1_pulse", start_cnt[1], 32'd1);
        wb_write(I_START, 32'h2);
        check_eq("start_running", start_cnt[1], 32'd1);
        check_rd(I_STATUS, 32'h0000_0002, "busy1_only");

        // Disable mid-run
        wb_write(I_CTRL, 32'h1);
        tick(2);
        check_eq("disable_srst", rst_cnt[1], 32'd1);
        check_rd(I_STATUS, 32'd0, "disable_status");
        pulse_done(1);
        check_rd(I_STATUS, 32'd0, "done_after_disable");

`ifdef SLOT_TIMEOUT_EN
        // Timeout after 10 RUN cycles on slot 2
        wb_write(I_CTRL, 32'hF);
        wb_write(I_TMO, 32'd10);
        check_rd(I_TMO, 32'd10, "tmo_write");
        wb_write(I_START, 32'h4);
        tick(8);
        check_eq("tmo_not_yet", {28'd0, slot_rst}, 32'd0);
        tick(1);
        check_eq("tmo_srst_now", {28'd0, slot_rst}, 32'h4);
        tick(1);
        check_eq("tmo_srst_once", {28'd0, slot_rst}, 32'd0);
        check_rd(I_STATUS, 32'h0004_0000, "status_tmo2");
        check_eq("tmo_srst_count", rst_cnt[2], 32'd1);
        wb_write(I_STATUS, 32'h0004_0000);

        // Done coincides with timeout on slot 1: done wins
        wb_write(I_TMO, 32'd4);
        wb_write(I_START, 32'h2);
        tick(3);
        slot_done[1] = 1'b1;
        #1;
        check_eq("done_beats_tmo_srst", {28'd0, slot_rst}, 32'd0);
        tick(1);
        slot_done[1] = 1'b0;
        check_rd(I_STATUS, 32'h0000_0200, "done_beats_tmo");
        check_eq("done_beats_tmo_cnt", rst_cnt[1], 32'd1);
        wb_write(I_STATUS, 32'h0000_0200);

        // TMO=0 behaves like 1
        wb_write(I_TMO, 32'd0);
        wb_write(I_START, 32'h8);
        tick(3);
        check_rd(I_STATUS, 32'h0008_0000, "tmo_zero");
        wb_write(I_STATUS, 32'h0008_0000);
        wb_write(I_TMO, 32'h0000_FFFF);
`endif

        // Reset in the middle of a run and a bus cycle
        wb_write(I_CTRL, 32'hF);
        wb_write(I_START, 32'h1);
        pulse_done(0);
        tick(2);
        check_eq("irq_before_rst", {31'd0, irq}, 32'd1);
        wb_write(I_START, 32'h8);
        @(posedge clk); #1;
        rst = 1'b1;
        stb = 1'b1; cyc = 1'b1; we = 1'b0;
        adr = {27'd0, I_TMO, 2'b00};
        #1;
        check_eq("midrst_ack", {31'd0, ack}, 32'd0);
        check_eq("midrst_outs", {23'd0, slot_start, slot_rst, irq}, 32'd0);
        tick(1);
        check_eq("midrst_ack2", {31'd0, ack}, 32'd0);
        check_eq("midrst_dat2", rdat, 32'd0);
        tick(1);
        rst = 1'b0;
        stb = 1'b0; cyc = 1'b0;
        tick(1);
        check_eq("midrst_no_srst", rst_cnt[3], RST3_EXP);
        check_rd(I_STATUS, 32'd0, "post_rst_status");
        check_rd(I_CTRL, 32'd0, "post_rst_ctrl");
        check_rd(I_TMO, TMO_RESET, "post_rst_tmo");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/slot_controller.md
SLOT_CONTROLLER -- requirements
Module: slot_controller

Interface
REQ-001 The block SHALL have parameter NSLOTS, default 4, legal 1..8: number of accelerator slots managed.
REQ-002 The block SHALL have parameter TMO_W, default 16, legal 8..32: width of the per-slot timeout counter and limit register.
REQ-003 The block SHALL use one clock, wb_clk_i; reset is synchronous and active-high.
REQ-004 The block SHALL have the following ports (name, direction, width, meaning):
- wb_clk_i, in, 1: clock.
- wb_rst_i, in, 1: synchronous active-high reset.
- wbs_stb_i, in, 1: Wishbone strobe.
- wbs_cyc_i, in, 1: Wishbone cycle.
- wbs_we_i, in, 1: write enable.
- wbs_sel_i, in, 4: byte selects; ignored, all writes are full-word.
- wbs_adr_i, in, 32: address; bits [4:2] select the register.
- wbs_dat_i, in, 32: write data.
- wbs_ack_o, out, 1: acknowledge.
- wbs_dat_o, out, 32: read data.
- slot_start_o, out, NSLOTS: one-cycle start pulse per slot.
- slot_rst_o, out, NSLOTS: one-cycle per-slot soft-reset pulse.
- slot_done_i, in, NSLOTS: per-slot completion level or pulse.
- irq_o, out, 1: interrupt, level.

Function
REQ-005 Register map (word index = adr[4:2]):
- 0 CTRL: [NSLOTS-1:0] slot enable, RW.
- 1 START: write 1 to start a slot; reads 0.
- 2 STATUS: [7:0] busy (RO), [15:8] done (sticky, W1C), [23:16] timeout (sticky, W1C).
- 3 TMO: [TMO_W-1:0] limit, RW.
- 4 IMASK: [1:0] = {timeout_ie, done_ie}, RW.
- Indices 5..7 read 0; writes to them are ignored.
- Bits at or above NSLOTS in any slot field read 0.
REQ-006 Bus handshake: wbs_ack_o SHALL go high exactly one cycle after a cycle where wbs_stb_i&wbs_cyc_i&!wbs_ack_o holds, and SHALL stay high for one cycle only.
REQ-007 Read timing: wbs_dat_o SHALL be valid while wbs_ack_o is high and SHALL be 0 otherwise.
REQ-008 Write timing: register writes SHALL take effect in the ack cycle.
REQ-009 Each slot SHALL run an independent FSM with states IDLE and RUN.
REQ-010 IDLE->RUN: on a START write with the bit set and CTRL enable=1.
- slot_start_o SHALL pulse in the same cycle.
- The timeout counter SHALL clear to 0.
REQ-011 A START write to a slot that is in RUN, or whose enable is 0, SHALL be ignored: no pulse and no state change.
REQ-012 RUN->IDLE on slot_done_i=1: set the slot's done bit.
REQ-013 RUN->IDLE on the counter reaching TMO-1: set the slot's timeout bit and pulse slot_rst_o for one cycle.
REQ-014 If slot_done_i and the timeout condition occur in the same cycle, done SHALL win: set done only, no slot_rst_o pulse.
REQ-015 Clearing a slot's CTRL enable while it is in RUN SHALL move it to IDLE next cycle and pulse slot_rst_o once, with no status bit set.
REQ-016 slot_done_i SHALL be ignored while the slot is in IDLE.
REQ-017 If a sticky bit's set event and its W1C clear occur in the same cycle, the set SHALL win.
REQ-018 The timeout counter SHALL increment once per cycle in RUN, SHALL saturate and never wrap, and TMO=0 SHALL be treated as 1.
REQ-019 irq_o SHALL equal (done_ie & |done) | (timeout_ie & |timeout), registered with one cycle latency.

Reset
REQ-020 While wb_rst_i=1, at the next clock edge:
- All FSMs SHALL go to IDLE.
- CTRL, STATUS, IMASK and the counters SHALL be 0.
- TMO SHALL be all-ones.
REQ-021 While in reset, wbs_ack_o, wbs_dat_o, slot_start_o, slot_rst_o and irq_o SHALL be 0.
REQ-022 A reset asserted during a bus cycle or during RUN SHALL abort it with no ack and no slot_rst_o pulse.

Configuration
REQ-023 With macro SLOT_TIMEOUT_EN defined, REQ-013, REQ-014 and REQ-018 apply.
REQ-024 With SLOT_TIMEOUT_EN undefined:
- No counters or TMO register SHALL be built.
- TMO and timeout bits SHALL read 0.
- A slot SHALL leave RUN only via done or disable.

Verification
REQ-025 Bus handshake: single read of TMO after reset -> ack 1 cycle after stb, data 0x0000FFFF (TMO_W=16); ack low the next cycle.
REQ-026 Done path: CTRL=0xF, START=0x1, slot_done_i[0] pulsed 5 cycles later -> slot_start_o[0] one pulse; STATUS=0x00000100; with IMASK=0x1, irq_o=1; writing STATUS=0x100 clears it and irq_o falls.
REQ-027 Timeout path: TMO=10, START slot 2, no done -> after 10 RUN cycles STATUS[18]=1, slot_rst_o[2] pulses once, busy[2]=0.
REQ-028 Simultaneous done and timeout: TMO=4, slot_done_i[1] asserted on the 4th RUN cycle -> done[1]=1, timeout[1]=0, no slot_rst_o.
REQ-029 Ignored starts: START to a disabled slot, then a START to a running slot -> no extra slot_start_o pulse.
REQ-030 Disable and reset: clearing enable mid-run -> slot_rst_o pulses, STATUS unchanged; wb_rst_i mid-run -> all outputs 0 next cycle.
